load_store_queue: RTL and testbench
===================================

Name: load_store_queue

Overview:
- In-order load/store queue directly upstream of memory_unit.
- Accepts memory ops from dispatch in program order and captures address/data from the AGU.
- Issues loads to memory_unit (mem_read/mem_addr/mem_rmask) and committed stores to its store path (mem_write/sb_*).
- Broadcasts load results and store-ready status back to the ROB/CDB.

Parameters:
- DEPTH, 16, queue entries (power of 2).
- PTR_LEN, $clog2(DEPTH)+1, pointer width including wrap bit.
- ROB_IDX_W, 5, ROB tag width.
- PREG_W, 6, physical register tag width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush; empties queue
- disp_valid  in  1  enqueue request
- disp_is_store  in  1  1=store, 0=load
- disp_funct3  in  3  RV32I width/sign code
- disp_rob_idx  in  ROB_IDX_W  ROB tag
- disp_pd  in  PREG_W  load destination preg
- lsq_full  out  1  queue full; dispatch must not assert disp_valid
- agu_valid  in  1  address (and store data) ready
- agu_rob_idx  in  ROB_IDX_W  tag to match
- agu_addr  in  32  effective byte address
- agu_wdata  in  32  store data (rs2 value)
- commit_valid  in  1  ROB retiring an entry
- commit_rob_idx  in  ROB_IDX_W  retiring tag
- mem_read  out  1  load request to memory_unit
- mem_addr  out  32  word-aligned load address
- mem_rmask  out  4  load byte mask
- mem_rdata  in  32  load word
- mem_ready  in  1  load data valid
- mem_free  in  1  memory_unit store queue empty
- mem_write  out  1  one-cycle store push
- sb_addr  out  32  word-aligned store address
- sb_wdata  out  32  lane-shifted store data
- sb_wmask  out  4  store byte mask
- cdb_valid, cdb_rob_idx, cdb_pd, cdb_data  out  1/ROB_IDX_W/PREG_W/32  load writeback
- st_done_valid, st_done_rob_idx  out  1/ROB_IDX_W  store ready-to-commit

Behaviour:
- Reset/flush: head=tail=0; all entry valid/addr_rdy/committed bits cleared; FSM=IDLE; all outputs 0.
- Flush during LD_WAIT drops mem_read the next cycle; no cdb pulse for the in-flight load.
- Pointers: wrap-bit full/empty. full = index equal and wrap bits differ; empty = index and wrap bits both equal.
- lsq_full is combinational.
- Enqueue: disp_valid && !full writes tail and increments tail. An enqueue while full is ignored.
- AGU: every valid entry whose rob_idx matches captures addr/wdata and sets addr_rdy.
- A store also pulses st_done_valid with its rob tag one cycle later (registered).
- Commit: commit_valid sets the committed bit on a matching valid store entry.
- Dequeue and issue happen only from head. FSM states:
  - IDLE:
    - head is a load, addr_rdy, and mem_free: drive mem_read=1, mem_addr=addr&~3, mem_rmask from funct3/addr[1:0] (LB 0001<<off, LH 0011<<off, LW 1111); go to LD_WAIT.
    - head is a store, addr_rdy, committed, and mem_free: pulse mem_write for 1 cycle with sb_wdata=wdata<<(8*off) and sb_wmask as above; pop head; go to ST_SETTLE.
  - LD_WAIT:
    - mem_read/addr/rmask held stable until mem_ready.
    - On mem_ready: next cycle cdb_valid=1 with data = (mem_rdata>>(8*off)) sign- or zero-extended per funct3 (LB/LH sign, LBU/LHU zero); pop head; mem_read=0; go to IDLE.
  - ST_SETTLE:
    - 2-cycle counter, then IDLE.
    - Covers memory_unit's registered mem_free deassertion, so no op issues on a stale mem_free.
- Misaligned halfword/word: masks are computed as specified with no trap.
- Simultaneous enqueue and pop are both honoured; count unchanged.
- Enqueue while full is permitted in the same cycle as a pop.
- An AGU fill and a commit in the same cycle to different entries both apply.

Optional Feature:
- LSQ_PERF_EN defined: adds 32-bit outputs perf_loads, perf_stores, perf_stall_cycles.
  - perf_stall_cycles counts cycles where head is valid and addr_rdy but mem_free=0.
  - All counters cleared on rst, saturate at max, and are not cleared by flush.
- LSQ_PERF_EN undefined: the ports and counters do not exist.

Decomposition:
- rv32i_types gets lsq_entry_t (valid, is_store, funct3, rob_idx, pd, addr, wdata, addr_rdy, committed) and lsq_state_t enum (IDLE, LD_WAIT, ST_SETTLE).
- Width-code constants come from the existing load/store funct3 enums.
- One sub-module, lsq_align: combinational mask, store-shift and load-extend logic.

Test Plan:
- LB from 0x1003, mem_rdata=0x80AA_BBCC -> mem_addr=0x1000, mem_rmask=1000, cdb_data=0xFFFF_FF80.
- SH to 0x2002, wdata=0x1234, commit matches -> single mem_write pulse, sb_addr=0x2000, sb_wmask=1100, sb_wdata=0x1234_0000; st_done pulses before commit.
- Store then load, mem_free held 0 for 5 cycles after store -> mem_read stays 0 until mem_free=1 and ST_SETTLE done.
- Fill 16 entries -> lsq_full=1 and a 17th disp is ignored; then pop and disp in the same cycle -> count stays 16, tail wraps to index 0 with wrap bit flipped.
- Flush in LD_WAIT -> mem_read=0 next cycle, no cdb_valid, lsq_full=0, empty queue.
- Reset asserted mid-store with ST_SETTLE active -> all outputs 0 next cycle, FSM=IDLE.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I types for the load/store queue: funct3 width codes, queue entry layout and FSM states.
package rv32i_types;

  localparam int LSQ_ROB_W  = 5;
  localparam int LSQ_PREG_W = 6;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  typedef struct packed {
    logic                  valid;
    logic                  is_store;
    logic [2:0]            funct3;
    logic [LSQ_ROB_W-1:0]  rob_idx;
    logic [LSQ_PREG_W-1:0] pd;
    logic [31:0]           addr;
    logic [31:0]           wdata;
    logic                  addr_rdy;
    logic                  committed;
  } lsq_entry_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LD_WAIT   = 2'd1,
    ST_SETTLE = 2'd2
  } lsq_state_t;

endpackage

// File: rtl/lsq_align.sv
// Byte-lane alignment for the LSQ head: access mask, store data shift, load data shift and extend.
module lsq_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  mask,
  output logic [31:0] sdata,
  output logic [31:0] ldata
);

  logic [31:0] shifted_s;

  assign sdata     = wdata << {off, 3'b000};
  assign shifted_s = rdata >> {off, 3'b000};

  // Byte mask; store codes share the low bits of the load codes, and misaligned lanes simply fall off the top.
  always_comb begin
    mask = 4'b0000;
    case (funct3)
      LB, LBU: mask = 4'b0001 << off;
      LH, LHU: mask = 4'b0011 << off;
      LW:      mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
  end

  // Load result extension
  always_comb begin
    ldata = shifted_s;
    case (funct3)
      LB:      ldata = {{24{shifted_s[7]}}, shifted_s[7:0]};
      LH:      ldata = {{16{shifted_s[15]}}, shifted_s[15:0]};
      LBU:     ldata = {24'h000000, shifted_s[7:0]};
      LHU:     ldata = {16'h0000, shifted_s[15:0]};
      default: ldata = shifted_s;
    endcase
  end

endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue feeding memory_unit; optional LSQ_PERF_EN adds saturating activity counters.
module load_store_queue
  import rv32i_types::*;
#(
  parameter int DEPTH     = 16,
  parameter int PTR_LEN   = $clog2(DEPTH) + 1,
  parameter int ROB_IDX_W = LSQ_ROB_W,
  parameter int PREG_W    = LSQ_PREG_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 disp_valid,
  input  logic                 disp_is_store,
  input  logic [2:0]           disp_funct3,
  input  logic [ROB_IDX_W-1:0] disp_rob_idx,
  input  logic [PREG_W-1:0]    disp_pd,
  output logic                 lsq_full,
  input  logic                 agu_valid,
  input  logic [ROB_IDX_W-1:0] agu_rob_idx,
  input  logic [31:0]          agu_addr,
  input  logic [31:0]          agu_wdata,
  input  logic                 commit_valid,
  input  logic [ROB_IDX_W-1:0] commit_rob_idx,
  output logic                 mem_read,
  output logic [31:0]          mem_addr,
  output logic [3:0]           mem_rmask,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ready,
  input  logic                 mem_free,
  output logic                 mem_write,
  output logic [31:0]          sb_addr,
  output logic [31:0]          sb_wdata,
  output logic [3:0]           sb_wmask,
  output logic                 cdb_valid,
  output logic [ROB_IDX_W-1:0] cdb_rob_idx,
  output logic [PREG_W-1:0]    cdb_pd,
  output logic [31:0]          cdb_data,
  output logic                 st_done_valid,
  output logic [ROB_IDX_W-1:0] st_done_rob_idx
`ifdef LSQ_PERF_EN
  ,
  output logic [31:0]          perf_loads,
  output logic [31:0]          perf_stores,
  output logic [31:0]          perf_stall_cycles
`endif
);

  localparam int IDX_W = PTR_LEN - 1;
  localparam logic [PTR_LEN-1:0] PTR_ONE = {{(PTR_LEN-1){1'b0}}, 1'b1};

  lsq_entry_t         q_r [DEPTH];
  logic [PTR_LEN-1:0] head_r, tail_r;
  lsq_state_t         state_r, state_n;
  logic               settle_cnt_r, settle_cnt_n;

  logic [IDX_W-1:0] head_idx_s, tail_idx_s;
  lsq_entry_t       head_s;
  logic             full_s, empty_s, head_ready_s;
  logic             issue_ld_s, issue_st_s, ld_done_s, pop_s, enq_s, st_fill_s;
  logic [3:0]       mask_s;
  logic [31:0]      sdata_s, ldata_s;

  assign head_idx_s   = head_r[IDX_W-1:0];
  assign tail_idx_s   = tail_r[IDX_W-1:0];
  assign full_s       = (head_idx_s == tail_idx_s) && (head_r[PTR_LEN-1] != tail_r[PTR_LEN-1]);
  assign empty_s      = (head_r == tail_r);
  assign head_s       = q_r[head_idx_s];
  assign head_ready_s = !empty_s && head_s.valid && head_s.addr_rdy;
  assign pop_s        = issue_st_s | ld_done_s;
  assign enq_s        = disp_valid && (!full_s || pop_s);
  assign lsq_full     = full_s;

  lsq_align u_align (
    .funct3 (head_s.funct3),
    .off    (head_s.addr[1:0]),
    .wdata  (head_s.wdata),
    .rdata  (mem_rdata),
    .mask   (mask_s),
    .sdata  (sdata_s),
    .ldata  (ldata_s)
  );

  // Any valid store picking up its address this cycle reports store-ready next cycle
  always_comb begin
    st_fill_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      st_fill_s = st_fill_s | (agu_valid && q_r[i].valid && q_r[i].is_store &&
                               (q_r[i].rob_idx == agu_rob_idx));
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_r      <= IDLE;
      settle_cnt_r <= 1'b0;
    end else begin
      state_r      <= state_n;
      settle_cnt_r <= settle_cnt_n;
    end
  end

  // FSM next state and issue decisions
  always_comb begin
    state_n      = state_r;
    settle_cnt_n = settle_cnt_r;
    issue_ld_s   = 1'b0;
    issue_st_s   = 1'b0;
    ld_done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (head_ready_s && mem_free && !head_s.is_store) begin
          issue_ld_s = 1'b1;
          state_n    = LD_WAIT;
        end else if (head_ready_s && mem_free && head_s.is_store && head_s.committed) begin
          issue_st_s   = 1'b1;
          settle_cnt_n = 1'b0;
          state_n      = ST_SETTLE;
        end else begin
          state_n = IDLE;
        end
      end
      LD_WAIT: begin
        if (mem_ready) begin
          ld_done_s = 1'b1;
          state_n   = IDLE;
        end else begin
          state_n = LD_WAIT;
        end
      end
      // Gives memory_unit's registered mem_free time to drop after our push
      ST_SETTLE: begin
        if (settle_cnt_r) begin
          settle_cnt_n = 1'b0;
          state_n      = IDLE;
        end else begin
          settle_cnt_n = 1'b1;
          state_n      = ST_SETTLE;
        end
      end
      default: begin
        settle_cnt_n = 1'b0;
        state_n      = IDLE;
      end
    endcase
  end

  // Queue storage and pointers; an enqueue into the slot being popped wins
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_r <= '0;
      tail_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_r[i].valid     <= 1'b0;
        q_r[i].addr_rdy  <= 1'b0;
        q_r[i].committed <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (agu_valid && q_r[i].valid && (q_r[i].rob_idx == agu_rob_idx)) begin
          q_r[i].addr     <= agu_addr;
          q_r[i].wdata    <= agu_wdata;
          q_r[i].addr_rdy <= 1'b1;
        end
        if (commit_valid && q_r[i].valid && q_r[i].is_store &&
            (q_r[i].rob_idx == commit_rob_idx)) begin
          q_r[i].committed <= 1'b1;
        end
      end
      if (pop_s) begin
        q_r[head_idx_s].valid <= 1'b0;
        head_r                <= head_r + PTR_ONE;
      end
      if (enq_s) begin
        q_r[tail_idx_s] <= '{valid: 1'b1, is_store: disp_is_store, funct3: disp_funct3,
                             rob_idx: disp_rob_idx, pd: disp_pd, addr: 32'h0000_0000,
                             wdata: 32'h0000_0000, addr_rdy: 1'b0, committed: 1'b0};
        tail_r          <= tail_r + PTR_ONE;
      end
    end
  end

  // Registered memory, CDB and store-ready outputs
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mem_read        <= 1'b0;
      mem_addr        <= 32'h0000_0000;
      mem_rmask       <= 4'b0000;
      mem_write       <= 1'b0;
      sb_addr         <= 32'h0000_0000;
      sb_wdata        <= 32'h0000_0000;
      sb_wmask        <= 4'b0000;
      cdb_valid       <= 1'b0;
      cdb_rob_idx     <= '0;
      cdb_pd          <= '0;
      cdb_data        <= 32'h0000_0000;
      st_done_valid   <= 1'b0;
      st_done_rob_idx <= '0;
    end else begin
      mem_write     <= issue_st_s;
      cdb_valid     <= ld_done_s;
      st_done_valid <= st_fill_s;
      if (st_fill_s) begin
        st_done_rob_idx <= agu_rob_idx;
      end
      if (issue_ld_s) begin
        mem_read  <= 1'b1;
        mem_addr  <= {head_s.addr[31:2], 2'b00};
        mem_rmask <= mask_s;
      end else if (ld_done_s) begin
        mem_read  <= 1'b0;
        mem_addr  <= 32'h0000_0000;
        mem_rmask <= 4'b0000;
      end
      if (issue_st_s) begin
        sb_addr  <= {head_s.addr[31:2], 2'b00};
        sb_wdata <= sdata_s;
        sb_wmask <= mask_s;
      end
      if (ld_done_s) begin
        cdb_rob_idx <= head_s.rob_idx;
        cdb_pd      <= head_s.pd;
        cdb_data    <= ldata_s;
      end
    end
  end

`ifdef LSQ_PERF_EN
  // Saturating activity counters; they survive flush
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_loads        <= 32'h0000_0000;
      perf_stores       <= 32'h0000_0000;
      perf_stall_cycles <= 32'h0000_0000;
    end else begin
      if (issue_ld_s && !flush && (perf_loads != 32'hFFFF_FFFF)) begin
        perf_loads <= perf_loads + 32'd1;
      end
      if (issue_st_s && !flush && (perf_stores != 32'hFFFF_FFFF)) begin
        perf_stores <= perf_stores + 32'd1;
      end
      if (head_ready_s && !mem_free && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_load_store_queue.sv
// Directed self-checking bench for load_store_queue (default build, LSQ_PERF_EN undefined).
module tb_load_store_queue;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        disp_valid, disp_is_store;
  logic [2:0]  disp_funct3;
  logic [4:0]  disp_rob_idx;
  logic [5:0]  disp_pd;
  logic        lsq_full;
  logic        agu_valid;
  logic [4:0]  agu_rob_idx;
  logic [31:0] agu_addr, agu_wdata;
  logic        commit_valid;
  logic [4:0]  commit_rob_idx;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [31:0] mem_rdata;
  logic        mem_ready, mem_free, mem_write;
  logic [31:0] sb_addr, sb_wdata;
  logic [3:0]  sb_wmask;
  logic        cdb_valid;
  logic [4:0]  cdb_rob_idx;
  logic [5:0]  cdb_pd;
  logic [31:0] cdb_data;
  logic        st_done_valid;
  logic [4:0]  st_done_rob_idx;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  load_store_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_is_store(disp_is_store), .disp_funct3(disp_funct3),
    .disp_rob_idx(disp_rob_idx), .disp_pd(disp_pd), .lsq_full(lsq_full),
    .agu_valid(agu_valid), .agu_rob_idx(agu_rob_idx), .agu_addr(agu_addr), .agu_wdata(agu_wdata),
    .commit_valid(commit_valid), .commit_rob_idx(commit_rob_idx),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_rmask(mem_rmask),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_free(mem_free),
    .mem_write(mem_write), .sb_addr(sb_addr), .sb_wdata(sb_wdata), .sb_wmask(sb_wmask),
    .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_pd(cdb_pd), .cdb_data(cdb_data),
    .st_done_valid(st_done_valid), .st_done_rob_idx(st_done_rob_idx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic st, input logic [2:0] f3, input logic [4:0] rob, input logic [5:0] pd);
    disp_valid = 1'b1; disp_is_store = st; disp_funct3 = f3; disp_rob_idx = rob; disp_pd = pd;
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic agu(input logic [4:0] rob, input logic [31:0] addr, input logic [31:0] wdata);
    agu_valid = 1'b1; agu_rob_idx = rob; agu_addr = addr; agu_wdata = wdata;
    tick();
    agu_valid = 1'b0;
  endtask

  task automatic commit(input logic [4:0] rob);
    commit_valid = 1'b1; commit_rob_idx = rob;
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic wait_read(output int n);
    n = 0;
    while (mem_read !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_write(output int n);
    n = 0;
    while (mem_write !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if (lsq_full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", lsq_full); end
    vectors++;
    if ({mem_read, mem_write, cdb_valid, st_done_valid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b want 0000", {mem_read, mem_write, cdb_valid, st_done_valid});
    end
    vectors++;
    if (dut.state_r !== IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want IDLE", dut.state_r); end
  endtask

  task automatic test_load_lb();
    int n;
    disp(1'b0, LB, 5'd3, 6'd7);
    agu(5'd3, 32'h0000_1003, 32'h0);
    vectors++;
    if (st_done_valid !== 1'b0) begin miscompares++; $display("FAIL lb_no_st_done: got %b want 0", st_done_valid); end
    wait_read(n);
    vectors++;
    if (n >= 20) begin miscompares++; $display("FAIL lb_issue_timeout: mem_read never rose"); end
    vectors++;
    if (mem_addr !== 32'h0000_1000) begin miscompares++; $display("FAIL lb_addr: got %h want 00001000", mem_addr); end
    vectors++;
    if (mem_rmask !== 4'b1000) begin miscompares++; $display("FAIL lb_rmask: got %b want 1000", mem_rmask); end
    tick();
    vectors++;
    if (mem_read !== 1'b1 || mem_addr !== 32'h0000_1000) begin
      miscompares++; $display("FAIL lb_hold: got read=%b addr=%h want 1/00001000", mem_read, mem_addr);
    end
    mem_rdata = 32'h80AA_BBCC; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    vectors++;
    if (cdb_valid !== 1'b1 || cdb_data !== 32'hFFFF_FF80) begin
      miscompares++; $display("FAIL lb_cdb: got v=%b data=%h want 1/ffffff80", cdb_valid, cdb_data);
    end
    vectors++;
    if (cdb_rob_idx !== 5'd3 || cdb_pd !== 6'd7 || mem_read !== 1'b0) begin
      miscompares++; $display("FAIL lb_tags: got rob=%0d pd=%0d read=%b want 3/7/0", cdb_rob_idx, cdb_pd, mem_read);
    end
    tick();
    vectors++;
    if (cdb_valid !== 1'b0) begin miscompares++; $display("FAIL lb_cdb_pulse: got %b want 0", cdb_valid); end
  endtask

  task automatic test_store_sh();
    int pulses;
    logic [31:0] a, d;
    logic [3:0] m;
    pulses = 0; a = 32'h0; d = 32'h0; m = 4'h0;
    disp(1'b1, SH, 5'd5, 6'd0);
    agu(5'd5, 32'h0000_2002, 32'h0000_1234);
    vectors++;
    if (st_done_valid !== 1'b1 || st_done_rob_idx !== 5'd5) begin
      miscompares++; $display("FAIL sh_st_done: got v=%b rob=%0d want 1/5", st_done_valid, st_done_rob_idx);
    end
    for (int k = 0; k < 3; k++) begin
      if (mem_write === 1'b1) pulses++;
      tick();
    end
    vectors++;
    if (pulses !== 0) begin miscompares++; $display("FAIL sh_precommit_write: got %0d pulses want 0", pulses); end
    commit(5'd5);
    for (int k = 0; k < 6; k++) begin
      tick();
      if (mem_write === 1'b1) begin pulses++; a = sb_addr; d = sb_wdata; m = sb_wmask; end
    end
    vectors++;
    if (pulses !== 1) begin miscompares++; $display("FAIL sh_pulses: got %0d want 1", pulses); end
    vectors++;
    if (a !== 32'h0000_2000 || m !== 4'b1100 || d !== 32'h1234_0000) begin
      miscompares++; $display("FAIL sh_fields: got addr=%h mask=%b data=%h want 00002000/1100/12340000", a, m, d);
    end
  endtask

  task automatic test_store_then_load();
    int n;
    logic seen;
    seen = 1'b0;
    disp(1'b1, SW, 5'd6, 6'd0);
    disp(1'b0, LW, 5'd7, 6'd9);
    agu(5'd6, 32'h0000_3000, 32'hDEAD_BEEF);
    vectors++;
    if (st_done_valid !== 1'b1 || st_done_rob_idx !== 5'd6) begin
      miscompares++; $display("FAIL stl_st_done: got v=%b rob=%0d want 1/6", st_done_valid, st_done_rob_idx);
    end
    agu_valid = 1'b1; agu_rob_idx = 5'd7; agu_addr = 32'h0000_3004;
    commit_valid = 1'b1; commit_rob_idx = 5'd6;
    tick();
    agu_valid = 1'b0; commit_valid = 1'b0;
    wait_write(n);
    vectors++;
    if (n >= 20 || sb_addr !== 32'h0000_3000 || sb_wmask !== 4'b1111 || sb_wdata !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL stl_store: got n=%0d addr=%h mask=%b data=%h want <20/00003000/1111/deadbeef",
                              n, sb_addr, sb_wmask, sb_wdata);
    end
    mem_free = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (mem_read === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL stl_blocked: got mem_read=1 want 0 while mem_free=0"); end
    mem_free = 1'b1;
    wait_read(n);
    vectors++;
    if (n !== 1) begin miscompares++; $display("FAIL stl_release: got %0d cycles want 1", n); end
    vectors++;
    if (mem_addr !== 32'h0000_3004 || mem_rmask !== 4'b1111) begin
      miscompares++; $display("FAIL stl_load_req: got addr=%h mask=%b want 00003004/1111", mem_addr, mem_rmask);
    end
    mem_rdata = 32'h1122_3344; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    vectors++;
    if (cdb_valid !== 1'b1 || cdb_data !== 32'h1122_3344 || cdb_rob_idx !== 5'd7 || cdb_pd !== 6'd9) begin
      miscompares++; $display("FAIL stl_cdb: got v=%b data=%h rob=%0d pd=%0d want 1/11223344/7/9",
                              cdb_valid, cdb_data, cdb_rob_idx, cdb_pd);
    end
  endtask

  task automatic test_back_to_back();
    int n, m;
    m = 0;
    disp(1'b1, SW, 5'd10, 6'd0);
    disp(1'b0, LHU, 5'd11, 6'd12);
    agu(5'd10, 32'h0000_4000, 32'h0000_0055);
    agu(5'd11, 32'h0000_4002, 32'h0);
    commit(5'd10);
    wait_write(n);
    while (mem_read !== 1'b1 && m < 20) begin
      tick();
      m++;
    end
    vectors++;
    if (n >= 20 || m !== 3) begin miscompares++; $display("FAIL b2b_settle: got write_wait=%0d settle=%0d want <20/3", n, m); end
    vectors++;
    if (mem_addr !== 32'h0000_4000 || mem_rmask !== 4'b1100) begin
      miscompares++; $display("FAIL b2b_lhu_req: got addr=%h mask=%b want 00004000/1100", mem_addr, mem_rmask);
    end
    mem_rdata = 32'h89AB_0000; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    vectors++;
    if (cdb_valid !== 1'b1 || cdb_data !== 32'h0000_89AB) begin
      miscompares++; $display("FAIL b2b_lhu_data: got v=%b data=%h want 1/000089ab", cdb_valid, cdb_data);
    end
  endtask

  task automatic test_full_wrap();
    int n;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        vectors++;
        if (lsq_full !== 1'b0) begin miscompares++; $display("FAIL full_early: got %b want 0 at 15 entries", lsq_full); end
      end
      disp(1'b0, LW, 5'(i), 6'(i));
    end
    vectors++;
    if (lsq_full !== 1'b1 || dut.tail_r !== 5'b10000) begin
      miscompares++; $display("FAIL full_set: got full=%b tail=%b want 1/10000", lsq_full, dut.tail_r);
    end
    disp(1'b0, LW, 5'd20, 6'd20);
    vectors++;
    if (dut.tail_r !== 5'b10000) begin miscompares++; $display("FAIL full_ignore: got tail=%b want 10000", dut.tail_r); end
    agu(5'd0, 32'h0000_0100, 32'h0);
    wait_read(n);
    mem_rdata = 32'h0000_00AB; mem_ready = 1'b1;
    disp_valid = 1'b1; disp_is_store = 1'b0; disp_funct3 = LW; disp_rob_idx = 5'd21; disp_pd = 6'd21;
    tick();
    mem_ready = 1'b0; disp_valid = 1'b0;
    vectors++;
    if (n >= 20 || cdb_valid !== 1'b1 || cdb_rob_idx !== 5'd0) begin
      miscompares++; $display("FAIL wrap_pop: got n=%0d v=%b rob=%0d want <20/1/0", n, cdb_valid, cdb_rob_idx);
    end
    vectors++;
    if (dut.tail_r !== 5'b10001 || dut.head_r !== 5'b00001 || lsq_full !== 1'b1) begin
      miscompares++; $display("FAIL wrap_ptrs: got tail=%b head=%b full=%b want 10001/00001/1",
                              dut.tail_r, dut.head_r, lsq_full);
    end
  endtask

  task automatic test_flush();
    int n;
    logic seen;
    seen = 1'b0;
    agu(5'd1, 32'h0000_0200, 32'h0);
    wait_read(n);
    tick();
    vectors++;
    if (n >= 20 || dut.state_r !== LD_WAIT) begin
      miscompares++; $display("FAIL flush_setup: got n=%0d state=%0d want <20/LD_WAIT", n, dut.state_r);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++;
    if (mem_read !== 1'b0 || cdb_valid !== 1'b0 || lsq_full !== 1'b0) begin
      miscompares++; $display("FAIL flush_out: got read=%b cdb=%b full=%b want 0/0/0", mem_read, cdb_valid, lsq_full);
    end
    vectors++;
    if (dut.head_r !== 5'd0 || dut.tail_r !== 5'd0) begin
      miscompares++; $display("FAIL flush_empty: got head=%0d tail=%0d want 0/0", dut.head_r, dut.tail_r);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (cdb_valid === 1'b1 || mem_read === 1'b1) seen = 1'b1;
      tick();
    end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL flush_no_cdb: got cdb/read activity want none"); end
  endtask

  task automatic test_reset_mid_store();
    int n;
    disp(1'b1, SB, 5'd9, 6'd0);
    agu(5'd9, 32'h0000_5001, 32'h0000_00AB);
    commit(5'd9);
    wait_write(n);
    vectors++;
    if (n >= 20 || sb_addr !== 32'h0000_5000 || sb_wmask !== 4'b0010 || sb_wdata !== 32'h0000_AB00) begin
      miscompares++; $display("FAIL sb_fields: got n=%0d addr=%h mask=%b data=%h want <20/00005000/0010/0000ab00",
                              n, sb_addr, sb_wmask, sb_wdata);
    end
    vectors++;
    if (dut.state_r !== ST_SETTLE) begin miscompares++; $display("FAIL sb_settle: got state=%0d want ST_SETTLE", dut.state_r); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (dut.state_r !== IDLE) begin miscompares++; $display("FAIL rst_mid_state: got %0d want IDLE", dut.state_r); end
    vectors++;
    if ({mem_read, mem_write, cdb_valid, st_done_valid, lsq_full} !== 5'b00000 ||
        sb_wmask !== 4'b0000 || sb_addr !== 32'h0 || sb_wdata !== 32'h0) begin
      miscompares++; $display("FAIL rst_mid_outs: got strobes=%b mask=%b addr=%h data=%h want 0",
                              {mem_read, mem_write, cdb_valid, st_done_valid, lsq_full}, sb_wmask, sb_addr, sb_wdata);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    disp_valid = 1'b0; disp_is_store = 1'b0; disp_funct3 = 3'b000; disp_rob_idx = 5'd0; disp_pd = 6'd0;
    agu_valid = 1'b0; agu_rob_idx = 5'd0; agu_addr = 32'h0; agu_wdata = 32'h0;
    commit_valid = 1'b0; commit_rob_idx = 5'd0;
    mem_rdata = 32'h0; mem_ready = 1'b0; mem_free = 1'b1;
    test_reset();
    test_load_lb();
    test_store_sh();
    test_store_then_load();
    test_back_to_back();
    test_full_wrap();
    test_flush();
    test_reset_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
